// File: rtl/axil_param_regfile_if.sv
// AXI4-Lite bus bundle for axil_param_regfile: the five channels with
// master/slave views. Clock and reset stay outside the bundle.
interface axil_param_regfile_if #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 8
);
   logic [C_S_AXI_ADDR_WIDTH-1:0]     AWADDR;
   logic [2:0]                        AWPROT;
   logic                              AWVALID;
   logic                              AWREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]     WDATA;
   logic [C_S_AXI_DATA_WIDTH/8-1:0]   WSTRB;
   logic                              WVALID;
   logic                              WREADY;
   logic [1:0]                        BRESP;
   logic                              BVALID;
   logic                              BREADY;
   logic [C_S_AXI_ADDR_WIDTH-1:0]     ARADDR;
   logic [2:0]                        ARPROT;
   logic                              ARVALID;
   logic                              ARREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]     RDATA;
   logic [1:0]                        RRESP;
   logic                              RVALID;
   logic                              RREADY;

   modport slave (
      input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
             ARADDR, ARPROT, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport master (
      output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
             ARADDR, ARPROT, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
endinterface

// File: rtl/axil_param_regfile.sv
// AXI4-Lite register file of NUM_REGS words with byte strobes and per-register write pulses.
// Optional macro AXIL_REGFILE_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axil_param_regfile #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int NUM_REGS           = 8,
   parameter int C_S_AXI_ADDR_WIDTH = 8
) (
   input  logic                                  ACLK,
   input  logic                                  ARESETN,
   axil_param_regfile_if.slave                   s_axi,
   output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_o,
   output logic [NUM_REGS-1:0]                   wr_pulse_o
);
   localparam int DW       = C_S_AXI_DATA_WIDTH;
   localparam int AW       = C_S_AXI_ADDR_WIDTH;
   localparam int NB       = DW / 8;
   localparam int ADDR_LSB = $clog2(NB);
   localparam int IDX_W    = $clog2(NUM_REGS);

   localparam logic [0:0] W_IDLE = 1'b0;
   localparam logic [0:0] W_RESP = 1'b1;
   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;

   localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REGFILE_SLVERR_EN
   localparam logic [1:0] RESP_OOR  = 2'b10;
`else
   localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

   function automatic logic addr_in_range(input logic [AW-1:0] a);
      return (a >> (ADDR_LSB + IDX_W)) == '0;
   endfunction

   function automatic logic [IDX_W-1:0] addr_index(input logic [AW-1:0] a);
      return a[ADDR_LSB +: IDX_W];
   endfunction

   logic [DW-1:0]    regs [NUM_REGS];
   logic             rdy_en;
   logic [0:0]       w_state;
   logic [0:0]       r_state;
   logic             aw_held;
   logic             w_held;
   logic [AW-1:0]    aw_buf;
   logic [DW-1:0]    w_buf;
   logic [NB-1:0]    strb_buf;
   logic             bvalid;
   logic [1:0]       bresp;
   logic             rvalid;
   logic [1:0]       rresp;
   logic [DW-1:0]    rdata;

   logic             aw_ready, w_ready, ar_ready;
   logic             aw_hs, w_hs, ar_hs, commit;
   logic [AW-1:0]    wr_addr;
   logic [DW-1:0]    wr_data;
   logic [NB-1:0]    wr_strb;
   logic             wr_ok, rd_ok;
   logic [IDX_W-1:0] wr_idx, rd_idx;
   logic             unused_prot;

   // Readys are derived from registered state, so they stay low through reset
   // and rise one edge after ARESETN is released (rdy_en).
   assign aw_ready = rdy_en && (w_state == W_IDLE) && !aw_held;
   assign w_ready  = rdy_en && (w_state == W_IDLE) && !w_held;
   assign ar_ready = rdy_en && (r_state == R_IDLE);

   assign aw_hs  = s_axi.AWVALID && aw_ready;
   assign w_hs   = s_axi.WVALID && w_ready;
   assign ar_hs  = s_axi.ARVALID && ar_ready;
   assign commit = (aw_held || aw_hs) && (w_held || w_hs);

   assign wr_addr = aw_held ? aw_buf   : s_axi.AWADDR;
   assign wr_data = w_held  ? w_buf    : s_axi.WDATA;
   assign wr_strb = w_held  ? strb_buf : s_axi.WSTRB;
   assign wr_ok   = addr_in_range(wr_addr);
   assign wr_idx  = addr_index(wr_addr);
   assign rd_ok   = addr_in_range(s_axi.ARADDR);
   assign rd_idx  = addr_index(s_axi.ARADDR);

   assign unused_prot = ^{s_axi.AWPROT, s_axi.ARPROT};

   assign s_axi.AWREADY = aw_ready;
   assign s_axi.WREADY  = w_ready;
   assign s_axi.ARREADY = ar_ready;
   assign s_axi.BVALID  = bvalid;
   assign s_axi.BRESP   = bresp;
   assign s_axi.RVALID  = rvalid;
   assign s_axi.RRESP   = rresp;
   assign s_axi.RDATA   = rdata;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
      assign regs_o[g*DW +: DW] = regs[g];
   end

   // Holding buffers for whichever of AW/W arrives first.
   always_ff @(posedge ACLK) begin
      if (aw_hs) aw_buf <= s_axi.AWADDR;
      if (w_hs) begin
         w_buf    <= s_axi.WDATA;
         strb_buf <= s_axi.WSTRB;
      end
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         rdy_en     <= 1'b0;
         w_state    <= W_IDLE;
         r_state    <= R_IDLE;
         aw_held    <= 1'b0;
         w_held     <= 1'b0;
         bvalid     <= 1'b0;
         bresp      <= RESP_OKAY;
         rvalid     <= 1'b0;
         rresp      <= RESP_OKAY;
         rdata      <= '0;
         wr_pulse_o <= '0;
         for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      end else begin
         rdy_en     <= 1'b1;
         wr_pulse_o <= '0;

         if (w_state == W_IDLE) begin
            if (commit) begin
               aw_held <= 1'b0;
               w_held  <= 1'b0;
               if (wr_ok) begin
                  for (int i = 0; i < NB; i++)
                     if (wr_strb[i]) regs[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                  if (|wr_strb) wr_pulse_o[wr_idx] <= 1'b1;
               end
               bvalid  <= 1'b1;
               bresp   <= wr_ok ? RESP_OKAY : RESP_OOR;
               w_state <= W_RESP;
            end else begin
               if (aw_hs) aw_held <= 1'b1;
               if (w_hs)  w_held  <= 1'b1;
            end
         end else if (s_axi.BREADY) begin
            bvalid  <= 1'b0;
            w_state <= W_IDLE;
         end

         // Read samples regs before this edge's write lands, so a colliding
         // write to the same word returns the old value.
         if (r_state == R_IDLE) begin
            if (ar_hs) begin
               rdata   <= rd_ok ? regs[rd_idx] : '0;
               rresp   <= rd_ok ? RESP_OKAY : RESP_OOR;
               rvalid  <= 1'b1;
               r_state <= R_DATA;
            end
         end else if (s_axi.RREADY) begin
            rvalid  <= 1'b0;
            r_state <= R_IDLE;
         end
      end
   end
endmodule

// File: tb/tb_axil_param_regfile.sv
// Directed bench for axil_param_regfile (DW=32, NUM_REGS=8) with hand-computed expectations.
module tb_axil_param_regfile;
   logic        clk = 1'b0;
   logic        ARESETN;
   logic [255:0] regs_o;
   logic [7:0]  wr_pulse_o;
   int          n_checks = 0;
   int          n_errs   = 0;
   int          pulse_cnt [8];

`ifdef AXIL_REGFILE_SLVERR_EN
   localparam logic [1:0] EXP_OOR = 2'b10;
`else
   localparam logic [1:0] EXP_OOR = 2'b00;
`endif

   axil_param_regfile_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8)) bus ();

   axil_param_regfile #(
      .C_S_AXI_DATA_WIDTH(32), .NUM_REGS(8), .C_S_AXI_ADDR_WIDTH(8)
   ) dut (
      .ACLK(clk), .ARESETN(ARESETN), .s_axi(bus),
      .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      for (int k = 0; k < 8; k++) if (wr_pulse_o[k]) pulse_cnt[k]++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] reg_val(input int k);
      return regs_o[k*32 +: 32];
   endfunction

   function automatic int pulse_total();
      int s = 0;
      for (int k = 0; k < 8; k++) s += pulse_cnt[k];
      return s;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                     output logic [1:0] resp);
      int  guard;
      logic aw_go, w_go;
      bus.AWADDR = addr; bus.WDATA = data; bus.WSTRB = strb;
      bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
      guard = 0;
      while ((bus.AWVALID || bus.WVALID) && guard < 20) begin
         aw_go = bus.AWREADY; w_go = bus.WREADY;
         tick();
         if (aw_go) bus.AWVALID = 1'b0;
         if (w_go)  bus.WVALID  = 1'b0;
         guard++;
      end
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
      guard = 0;
      while (!bus.BVALID && guard < 20) begin tick(); guard++; end
      check("wr_bvalid", bus.BVALID, 1);
      resp = bus.BRESP;
      bus.BREADY = 1'b1; tick(); bus.BREADY = 1'b0;
   endtask

   task automatic rd(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int  guard;
      logic ar_go;
      bus.ARADDR = addr; bus.ARVALID = 1'b1;
      guard = 0;
      while (bus.ARVALID && guard < 20) begin
         ar_go = bus.ARREADY;
         tick();
         if (ar_go) bus.ARVALID = 1'b0;
         guard++;
      end
      bus.ARVALID = 1'b0;
      check("rd_latency1", bus.RVALID, 1);
      data = bus.RDATA; resp = bus.RRESP;
      bus.RREADY = 1'b1; tick(); bus.RREADY = 1'b0;
   endtask

   initial begin
      logic [1:0]   resp;
      logic [31:0]  data;
      logic [255:0] snap;
      int           ptot;

      for (int k = 0; k < 8; k++) pulse_cnt[k] = 0;
      ARESETN = 1'b0;
      bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
      bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
      bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

      // Reset state
      repeat (3) tick();
      check("rst_awready", bus.AWREADY, 0);
      check("rst_wready", bus.WREADY, 0);
      check("rst_arready", bus.ARREADY, 0);
      check("rst_bvalid", bus.BVALID, 0);
      check("rst_rvalid", bus.RVALID, 0);
      check("rst_rdata", bus.RDATA, 0);
      check("rst_regs", |regs_o, 0);
      check("rst_pulse", wr_pulse_o, 0);
      ARESETN = 1'b1;
      check("rdy_before_edge", bus.AWREADY, 0);
      tick();
      check("rdy_after_release", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);

      // Fill and read back all registers
      for (int k = 0; k < 8; k++) begin
         wr(8'(k * 4), 32'(k + 1), 4'hF, resp);
         check("fill_bresp", resp, 2'b00);
      end
      for (int k = 0; k < 8; k++) begin
         rd(8'(k * 4), data, resp);
         check("fill_rdata", data, 32'(k + 1));
         check("fill_rresp", resp, 2'b00);
      end
      for (int k = 0; k < 8; k++) check("fill_pulse_cnt", pulse_cnt[k], 1);

      // W leads AW by three cycles
      bus.WDATA = 32'hDEADBEEF; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
      tick();
      bus.WVALID = 1'b0;
      check("wfirst_wready_low", bus.WREADY, 0);
      check("wfirst_awready_high", bus.AWREADY, 1);
      repeat (2) tick();
      check("wfirst_no_bvalid", bus.BVALID, 0);
      check("wfirst_reg_untouched", reg_val(2), 32'h3);
      bus.AWADDR = 8'h08; bus.AWVALID = 1'b1;
      tick();
      bus.AWVALID = 1'b0;
      check("wfirst_commit_bvalid", bus.BVALID, 1);
      check("wfirst_pulse", wr_pulse_o, 8'h04);
      check("wfirst_reg2", reg_val(2), 32'hDEADBEEF);
      check("wresp_awready_low", bus.AWREADY, 0);
      repeat (4) tick();
      check("bvalid_held", bus.BVALID, 1);
      check("bresp_held", bus.BRESP, 2'b00);
      check("pulse_one_cycle", wr_pulse_o, 8'h00);
      bus.BREADY = 1'b1; tick(); bus.BREADY = 1'b0;
      check("b_done", bus.BVALID, 0);
      check("back_idle_readys", {bus.AWREADY, bus.WREADY}, 2'b11);

      // Byte strobes
      wr(8'h08, 32'h11223344, 4'b0101, resp);
      rd(8'h08, data, resp);
      check("strb_merge", data, 32'hDE22BE44);

      // Zero strobe: no change, no pulse
      ptot = pulse_total();
      wr(8'h00, 32'hFFFFFFFF, 4'b0000, resp);
      check("strb0_bresp", resp, 2'b00);
      check("strb0_reg0", reg_val(0), 32'h1);
      check("strb0_no_pulse", pulse_total(), ptot);

      // Read and write to the same word in one cycle
      wr(8'h0C, 32'hA5A5A5A5, 4'hF, resp);
      bus.AWADDR = 8'h0C; bus.WDATA = 32'h5A5A5A5A; bus.WSTRB = 4'hF; bus.ARADDR = 8'h0C;
      bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1;
      tick();
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
      check("coll_rvalid", bus.RVALID, 1);
      check("coll_bvalid", bus.BVALID, 1);
      check("coll_old_value", bus.RDATA, 32'hA5A5A5A5);
      check("coll_reg3_new", reg_val(3), 32'h5A5A5A5A);
      bus.BREADY = 1'b1; bus.RREADY = 1'b1; tick(); bus.BREADY = 1'b0; bus.RREADY = 1'b0;
      rd(8'h0C, data, resp);
      check("coll_later_read", data, 32'h5A5A5A5A);

      // Out-of-range address
      snap = regs_o; ptot = pulse_total();
      wr(8'h40, 32'hFFFFFFFF, 4'hF, resp);
      check("oor_bresp", resp, EXP_OOR);
      rd(8'h40, data, resp);
      check("oor_rresp", resp, EXP_OOR);
      check("oor_rdata", data, 32'h0);
      check("oor_regs_same", regs_o == snap, 1);
      check("oor_no_pulse", pulse_total(), ptot);

      // Reset between AW and W
      bus.AWADDR = 8'h00; bus.AWVALID = 1'b1;
      tick();
      bus.AWVALID = 1'b0;
      check("midrst_aw_held", bus.AWREADY, 0);
      ARESETN = 1'b0;
      tick();
      check("midrst_readys", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b000);
      check("midrst_regs", |regs_o, 0);
      check("midrst_rdata", bus.RDATA, 0);
      repeat (3) tick();
      check("midrst_no_bvalid", bus.BVALID, 0);
      ARESETN = 1'b1;
      tick();
      wr(8'h00, 32'h12345678, 4'hF, resp);
      check("postrst_bresp", resp, 2'b00);
      rd(8'h00, data, resp);
      check("postrst_rdata", data, 32'h12345678);
      check("postrst_reg1_clear", reg_val(1), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/axil_param_regfile.md
AXIL_PARAM_REGFILE -- requirements
Module: axil_param_regfile

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI-Lite data width; legal values are 32 and 64.
REQ-002 SHALL have parameter NUM_REGS, default 8, register count; legal values are powers of 2 from 4 to 256.
REQ-003 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 8, byte address width; must be at least ADDR_LSB+log2(NUM_REGS), where ADDR_LSB = log2(C_S_AXI_DATA_WIDTH/8).
REQ-004 SHALL have port ACLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port ARESETN, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have ports AWADDR, AWPROT, AWVALID, AWREADY: the AXI4-Lite write address channel; AWPROT is ignored.
REQ-007 SHALL have ports WDATA, WSTRB (width DW/8), WVALID, WREADY: the write data channel.
REQ-008 SHALL have ports BRESP (2 bits), BVALID, BREADY: the write response channel.
REQ-009 SHALL have ports ARADDR, ARPROT, ARVALID, ARREADY: the read address channel; ARPROT is ignored.
REQ-010 SHALL have ports RDATA, RRESP, RVALID, RREADY: the read data channel.
REQ-011 SHALL have port regs_o, output, NUM_REGS*DW bits: all register contents, register k in slice [k*DW +: DW].
REQ-012 SHALL have port wr_pulse_o, output, NUM_REGS bits: bit k is high for one cycle when register k commits a write.

Function
REQ-013 SHALL decode the word index from addr[ADDR_LSB +: log2(NUM_REGS)]; an address is out of range if any bit above that field is nonzero; address bits below ADDR_LSB are ignored.
REQ-014 SHALL run a write FSM with states W_IDLE, W_RESP; in W_IDLE AWREADY and WREADY are each high until their own handshake occurs.
REQ-015 SHALL accept AW and W independently and in either order, holding the first one in a buffer; once both are held, or both arrive in the same cycle, it SHALL commit the write on the next edge.
REQ-016 SHALL commit the write as follows: byte i of the target register is updated only where WSTRB[i]=1; the matching wr_pulse_o bit rises; BVALID=1; the FSM enters W_RESP.
REQ-017 SHALL, in W_RESP, hold AWREADY=WREADY=0 and keep BVALID and BRESP stable until BREADY=1; on the cycle after the handshake it returns to W_IDLE with both readys high.
REQ-018 SHALL, if WSTRB=0 and the address is in range, update no byte, assert no pulse, and respond BRESP=OKAY.
REQ-019 SHALL run a read FSM with states R_IDLE, R_DATA; in R_IDLE ARREADY=1.
REQ-020 SHALL, on an AR handshake, register RDATA from current register values and RVALID=1 on the next edge (latency 1), set ARREADY=0, and enter R_DATA.
REQ-021 SHALL hold RDATA, RRESP and RVALID until RREADY=1, and return to R_IDLE on the next edge.
REQ-022 SHALL, when the AR handshake coincides with a write commit to the same register, return the old value.
REQ-023 SHALL keep the read and write FSMs independent; both may be active in the same cycle.
REQ-024 SHALL write regs_o only via AXI writes; wr_pulse_o SHALL be high for exactly one cycle per committed write.

Reset
REQ-025 SHALL, while ARESETN=0 at an edge, clear all registers, regs_o and wr_pulse_o to 0, drive BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0 and AWREADY=WREADY=ARREADY=0, and return both FSMs to idle.
REQ-026 SHALL raise the readys on the first edge after ARESETN returns to 1.
REQ-027 SHALL abandon any transaction in flight when reset occurs mid-operation, with no response issued.

Configuration
REQ-028 SHALL, with macro AXIL_REGFILE_SLVERR_EN defined, respond BRESP/RRESP=SLVERR (2'b10) to out-of-range accesses, with RDATA=0 and no register change.
REQ-029 SHALL, without the macro, respond OKAY to out-of-range accesses, with RDATA=0 and writes ignored.

Verification (DW=32, NUM_REGS=8)
REQ-030 SHALL cover: write 0x00000001..0x00000008 to 0x00..0x1C, then read them back -> each read matches, RRESP=OKAY, wr_pulse_o bits 0..7 each pulse once.
REQ-031 SHALL cover: W sent 3 cycles before AW to 0x08, data 0xDEADBEEF -> the commit happens one edge after the AW handshake, and BVALID is held through 4 cycles of BREADY=0.
REQ-032 SHALL cover: reg 2 = 0xDEADBEEF, then write 0x11223344 with WSTRB=4'b0101 -> reads 0xDE22BE44.
REQ-033 SHALL cover: read and write of 0x0C in the same cycle while reg 3 = 0xA5A5A5A5 and the write data is 0x5A5A5A5A -> the read returns 0xA5A5A5A5 and a later read returns 0x5A5A5A5A.
REQ-034 SHALL cover: a write and a read to 0x40 -> with AXIL_REGFILE_SLVERR_EN, BRESP=RRESP=2'b10 and RDATA=0; without it, OKAY; in both cases regs_o is unchanged.
REQ-035 SHALL cover: ARESETN=0 asserted after an AW handshake but before W -> all outputs 0, no BVALID; after release a fresh write to 0x00 succeeds normally.
